stack_xfer_sequencer: RTL and testbench

//  Sequential PUSH/POP micro-sequencer: own step counter replaces the external XPT-decoded tables.

---
 rtl/stack_xfer_sequencer_pkg.sv | 28 ++
 rtl/stack_xfer_phase_ctr.sv | 25 ++
 rtl/stack_xfer_sequencer.sv | 122 ++++++++++++
 tb/tb_stack_xfer_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stack_xfer_sequencer_pkg.sv
// Shared types and helpers for the PUSH/POP stack transfer sequencer.
// Holds the state encoding, default sizing and the data-select index/decode functions.
package stack_xfer_sequencer_pkg;

   localparam int unsigned DefBytes     = 2;
   localparam int unsigned DefNumGroups = 4;
   localparam int unsigned MaxSel       = 64;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StW0,
      StW1,
      StW2,
      StDone
   } state_e;

   function automatic int unsigned sel_index(input int unsigned grp, input int unsigned b,
                                             input int unsigned bytes);
      return grp * bytes + b;
   endfunction

   // Out-of-range index yields no selection, which covers unmapped register groups.
   function automatic logic [MaxSel-1:0] onehot(input int unsigned width, input int unsigned idx);
      return (idx < width) ? (MaxSel'(1) << idx) : '0;
   endfunction

endpackage

// File: rtl/stack_xfer_phase_ctr.sv
// Memory-phase generator: decodes W0/W1/W2 from the sequencer state and
// produces the next phase, holding W1 while memory is not ready.
module stack_xfer_phase_ctr
   import stack_xfer_sequencer_pkg::*;
(
   input  state_e     state,
   input  logic       ready,
   output logic [2:0] phase,
   output logic       last_phase,
   output state_e     phase_next
);

   always_comb begin
      phase      = {state == StW2, state == StW1, state == StW0};
      last_phase = (state == StW2);
      phase_next = state;
      unique case (state)
         StW0:    phase_next = StW1;
         StW1:    phase_next = ready ? StW2 : StW1;
         StW2:    phase_next = StW0;
         default: phase_next = state;
      endcase
   end

endmodule

// File: rtl/stack_xfer_sequencer.sv
// PUSH/POP micro-sequencer: moves one register group between register file and stack,
// driving SP inc/dec, address/data selects and W0..W2 memory phases with wait insertion.
module stack_xfer_sequencer
   import stack_xfer_sequencer_pkg::*;
#(
   parameter int unsigned BYTES      = DefBytes,
   parameter int unsigned NUM_GROUPS = DefNumGroups,
   localparam int unsigned GW        = (NUM_GROUPS > 2) ? $clog2(NUM_GROUPS) : 1,
   localparam int unsigned BW        = (BYTES > 2) ? $clog2(BYTES) : 1,
   localparam int unsigned SelW      = NUM_GROUPS * BYTES
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            Start,
   input  logic            Pop,
   input  logic [GW-1:0]   Group,
   input  logic            PC_Ready,
   output logic            PR_Dec_SP,
   output logic            PR_Inc_SP,
   output logic            PI_SelectAd_SP,
   output logic            PC_W0,
   output logic            PC_W1,
   output logic            PC_W2,
   output logic            PC_Write,
   output logic [SelW-1:0] PI_SelectDt,
   output logic            Busy,
   output logic            Pa_Ophd,
   output logic            P2_Set_CM1,
   output logic            PR_Reset_XPT
);

   state_e        state_q, state_d, phase_next;
   logic [BW-1:0] k_q, k_d;
   logic          pop_q, pop_d;
   logic [GW-1:0] grp_q, grp_d;
   logic [2:0]    phase;
   logic          last_phase;
   logic          last_k;
   logic          sel_en;
   int unsigned   b;

   stack_xfer_phase_ctr u_phase_ctr (
      .state      (state_q),
      .ready      (PC_Ready),
      .phase      (phase),
      .last_phase (last_phase),
      .phase_next (phase_next)
   );

   assign last_k = (k_q == BW'(BYTES - 1));

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      pop_d     = pop_q;
      grp_d     = grp_q;
      PR_Dec_SP = 1'b0;
      PR_Inc_SP = 1'b0;
      Pa_Ophd   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               pop_d   = Pop;
               grp_d   = Group;
               k_d     = '0;
               state_d = Pop ? StW0 : StPre;
            end
         end
         StPre: begin
            PR_Dec_SP = 1'b1;
            state_d   = StW0;
         end
         StW0, StW1: state_d = phase_next;
         StW2: begin
            PR_Inc_SP = pop_q;
            if (!last_k) begin
               k_d       = k_q + 1'b1;
               PR_Dec_SP = !pop_q;  // pre-decrement ahead of the next PUSH byte
               state_d   = phase_next;
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            Pa_Ophd = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // PUSH walks MSB..LSB and drives data for the whole cycle; POP walks LSB..MSB and latches in W2.
   always_comb begin
      b           = pop_q ? 32'(k_q) : BYTES - 1 - 32'(k_q);
      sel_en      = pop_q ? last_phase : |phase;
      PI_SelectDt = sel_en ? SelW'(onehot(SelW, sel_index(32'(grp_q), b, BYTES))) : '0;
   end

   assign PI_SelectAd_SP = |phase;
   assign PC_W0          = phase[0];
   assign PC_W1          = phase[1];
   assign PC_W2          = phase[2];
   assign PC_Write       = (|phase) & ~pop_q;
   assign Busy           = (state_q != StIdle) && (state_q != StDone);
   assign P2_Set_CM1     = Pa_Ophd;
   assign PR_Reset_XPT   = Pa_Ophd;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
         k_q     <= '0;
         pop_q   <= 1'b0;
         grp_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         pop_q   <= pop_d;
         grp_q   <= grp_d;
      end
   end

endmodule

// File: tb/tb_stack_xfer_sequencer.sv
// Directed bench for stack_xfer_sequencer: default 2-byte/4-group instance plus a
// 4-byte/8-group instance, with per-cycle traces checked against hand-computed values.
module tb_stack_xfer_sequencer;

   localparam int B_DEC = 10, B_INC = 9, B_AD = 8, B_W0 = 7, B_W1 = 6, B_W2 = 5;
   localparam int B_WR = 4, B_BUSY = 3, B_PA = 2, B_CM = 1, B_XPT = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       RESET, start, pop, ready, use4;
   logic [2:0] grp;

   logic a_dec, a_inc, a_ad, a_w0, a_w1, a_w2, a_wr, a_busy, a_pa, a_cm, a_xpt;
   logic b_dec, b_inc, b_ad, b_w0, b_w1, b_w2, b_wr, b_busy, b_pa, b_cm, b_xpt;
   logic [7:0]  a_sel;
   logic [31:0] b_sel;
   logic [10:0] a_out, b_out, m_out;
   logic [31:0] m_sel;

   stack_xfer_sequencer dut (
      .CLK(clk), .RESET(RESET), .Start(start & ~use4), .Pop(pop), .Group(grp[1:0]),
      .PC_Ready(ready), .PR_Dec_SP(a_dec), .PR_Inc_SP(a_inc), .PI_SelectAd_SP(a_ad),
      .PC_W0(a_w0), .PC_W1(a_w1), .PC_W2(a_w2), .PC_Write(a_wr), .PI_SelectDt(a_sel),
      .Busy(a_busy), .Pa_Ophd(a_pa), .P2_Set_CM1(a_cm), .PR_Reset_XPT(a_xpt)
   );

   stack_xfer_sequencer #(.BYTES(4), .NUM_GROUPS(8)) dut4 (
      .CLK(clk), .RESET(RESET), .Start(start & use4), .Pop(pop), .Group(grp),
      .PC_Ready(ready), .PR_Dec_SP(b_dec), .PR_Inc_SP(b_inc), .PI_SelectAd_SP(b_ad),
      .PC_W0(b_w0), .PC_W1(b_w1), .PC_W2(b_w2), .PC_Write(b_wr), .PI_SelectDt(b_sel),
      .Busy(b_busy), .Pa_Ophd(b_pa), .P2_Set_CM1(b_cm), .PR_Reset_XPT(b_xpt)
   );

   assign a_out = {a_dec, a_inc, a_ad, a_w0, a_w1, a_w2, a_wr, a_busy, a_pa, a_cm, a_xpt};
   assign b_out = {b_dec, b_inc, b_ad, b_w0, b_w1, b_w2, b_wr, b_busy, b_pa, b_cm, b_xpt};
   assign m_out = use4 ? b_out : a_out;
   assign m_sel = use4 ? b_sel : {24'b0, a_sel};

   int total = 0;
   int bad   = 0;
   logic [10:0] rec_out [0:31];
   logic [31:0] rec_sel [0:31];
   int          rec_n;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int cnt(input int bit_idx);
      int n = 0;
      for (int c = 1; c <= rec_n; c++) n += int'(rec_out[c][bit_idx]);
      return n;
   endfunction

   function automatic int first(input int bit_idx);
      for (int c = 1; c <= rec_n; c++) if (rec_out[c][bit_idx]) return c;
      return 0;
   endfunction

   // Start issued in cycle 0; hooks fire on the cycle index (0 = never).
   task automatic run(input int n, input logic p, input logic [2:0] g, input int rlo_a,
                      input int rlo_b, input int rst_at, input int s1, input int s2);
      for (int c = 0; c < 32; c++) begin
         rec_out[c] = '0;
         rec_sel[c] = '0;
      end
      rec_n = n;
      pop   = p;
      grp   = g;
      ready = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= n; c++) begin
         tick();
         rec_out[c] = m_out;
         rec_sel[c] = m_sel;
         start = (c == s1) || (c == s2);
         if (c == rlo_a) ready = 1'b0;
         if (c == rlo_b) ready = 1'b1;
         RESET = (c == rst_at);
      end
      start = 1'b0;
      ready = 1'b1;
      RESET = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      start = 1'b0;
      pop   = 1'b0;
      ready = 1'b1;
      use4  = 1'b0;
      grp   = '0;
      tick();
      tick();
      check("reset_out", {21'b0, a_out}, 32'h0);
      check("reset_sel", {24'b0, a_sel}, 32'h0);
      check("reset_out4", {21'b0, b_out} | b_sel, 32'h0);
      RESET = 1'b0;
      tick();

      // PUSH group 1, no waits
      run(10, 1'b0, 3'd1, 0, 0, 0, 0, 0);
      check("push_pre_dec", {31'b0, rec_out[1][B_DEC]}, 32'd1);
      check("push_pre_busy", {31'b0, rec_out[1][B_BUSY]}, 32'd1);
      check("push_w0_sel", rec_sel[2], 32'h08);
      check("push_w0_strobes", {29'b0, rec_out[2][B_AD], rec_out[2][B_W0], rec_out[2][B_WR]},
            32'd7);
      check("push_w2_dec", {31'b0, rec_out[4][B_DEC]}, 32'd1);
      check("push_b1_sel", rec_sel[5], 32'h04);
      check("push_dec_cnt", cnt(B_DEC), 32'd2);
      check("push_pa_cycle", first(B_PA), 32'd8);
      check("push_end_triple", {29'b0, rec_out[8][2:0]}, 32'd7);
      check("push_done_busy", {31'b0, rec_out[8][B_BUSY]}, 32'd0);
      check("push_pa_cnt", cnt(B_PA), 32'd1);

      // POP group 3, no waits
      run(9, 1'b1, 3'd3, 0, 0, 0, 0, 0);
      check("pop_w0_sel", rec_sel[1], 32'h0);
      check("pop_w0_write", {31'b0, rec_out[1][B_WR]}, 32'd0);
      check("pop_w2_sel0", rec_sel[3], 32'h40);
      check("pop_w2_sel1", rec_sel[6], 32'h80);
      check("pop_inc_cyc", {30'b0, rec_out[3][B_INC], rec_out[6][B_INC]}, 32'd3);
      check("pop_inc_cnt", cnt(B_INC), 32'd2);
      check("pop_dec_cnt", cnt(B_DEC), 32'd0);
      check("pop_pa_cycle", first(B_PA), 32'd7);

      // PUSH with two wait cycles in the first W1
      run(12, 1'b0, 3'd1, 3, 5, 0, 0, 0);
      check("wait_w1_held", {29'b0, rec_out[3][B_W1], rec_out[4][B_W1], rec_out[5][B_W1]},
            32'd7);
      check("wait_sel_stable", rec_sel[3] & rec_sel[4] & rec_sel[5], 32'h08);
      check("wait_w2_cycle", first(B_W2), 32'd6);
      check("wait_pa_cycle", first(B_PA), 32'd10);

      // RESET during second W1 of a PUSH
      run(9, 1'b0, 3'd1, 0, 0, 6, 0, 0);
      check("rst_w1_before", {31'b0, rec_out[6][B_W1]}, 32'd1);
      check("rst_out_zero", {21'b0, rec_out[7]} | rec_sel[7], 32'h0);
      check("rst_after_idle", {21'b0, rec_out[8] | rec_out[9]}, 32'h0);
      check("rst_no_pa", cnt(B_PA), 32'd0);
      run(10, 1'b0, 3'd1, 0, 0, 0, 0, 0);
      check("rst_clean_pa", first(B_PA), 32'd8);
      check("rst_clean_sel", rec_sel[5], 32'h04);

      // Start pulsed while busy and during DONE
      run(14, 1'b0, 3'd1, 0, 0, 0, 3, 8);
      check("ign_pa_cnt", cnt(B_PA), 32'd1);
      check("ign_pa_cycle", first(B_PA), 32'd8);
      check("ign_busy_cnt", cnt(B_BUSY), 32'd7);

      // 4-byte, 8-group instance: PUSH group 5
      use4 = 1'b1;
      run(16, 1'b0, 3'd5, 0, 0, 0, 0, 0);
      check("b4_sel0", rec_sel[2], 32'h0080_0000);
      check("b4_sel1", rec_sel[5], 32'h0040_0000);
      check("b4_sel2", rec_sel[8], 32'h0020_0000);
      check("b4_sel3", rec_sel[11], 32'h0010_0000);
      check("b4_dec_cnt", cnt(B_DEC), 32'd4);
      check("b4_pa_cycle", first(B_PA), 32'd14);
      use4 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
